gps_spi_packer: RTL and testbench
=================================

Name: gps_spi_packer

Overview:
Parametrised successor to the GPS-to-MCU bridge. Samples N-bit I/Q data from the MAX2769 front end, packs consecutive samples into fixed-width words, buffers them in a FIFO, and streams them to the MCU over an SPI-master link. The block runs entirely on MCU_CLK: MAX2769_CLK is treated as a sampled data input, not as a clock. Adds a self-test counter mode, overflow detection and a FIFO level report.

Parameters:
SAMPLE_BITS, 2, bits per I and per Q component; one sample is {I,Q}, 2*SAMPLE_BITS wide, with I in the upper bits.
WORD_BITS, 16, SPI frame width; must be an integer multiple of 2*SAMPLE_BITS.
FIFO_DEPTH, 8, number of words buffered; power of two, at least 2.
SCK_DIV, 2, MCU_CLK cycles per SCK half-period; at least 1.
SS_GAP, 4, minimum MCU_CLK cycles MCU_SS stays high between frames; at least 1.

Ports:
MCU_CLK  in  1  sole clock.
RESET  in  1  synchronous, active-high reset.
MAX2769_CLK  in  1  front-end sample clock, sampled as data.
GPS_I  in  SAMPLE_BITS  I sample bits.
GPS_Q  in  SAMPLE_BITS  Q sample bits.
SELF_TEST  in  1  1 = substitute counter pattern for live samples.
MCU_SCK  out  1  SPI clock, mode 0, idles low.
MCU_SS  out  1  SPI select, active low.
MCU_MOSI  out  1  SPI data, MSB first.
OVERFLOW  out  1  sticky; set when a word is dropped on a full FIFO.
FIFO_LEVEL  out  $clog2(FIFO_DEPTH+1)  words currently held.

Behaviour:
- Everything is one clock domain, and only MCU_CLK edges are used.
- Reset is synchronous and active-high. While RESET is high on an MCU_CLK edge:
  - MCU_SCK=0, MCU_SS=1, MCU_MOSI=0, OVERFLOW=0, FIFO_LEVEL=0.
  - FIFO is flushed, the packer sample count is 0, the self-test counter is 0 and the SPI FSM is in IDLE.
- Reset mid-frame: MCU_SS goes high and MCU_SCK goes low on the first edge with RESET high. The aborted word is lost.
- Input capture:
  - MAX2769_CLK, GPS_I and GPS_Q pass through a 2-flop synchroniser.
  - The cycle after the synchronised clock is seen going 0 to 1 produces a one-cycle strobe.
  - On the strobe, the synchronised {GPS_I,GPS_Q} is taken as the sample.
  - Latency from the MAX2769_CLK rise to the sample being taken is 3 MCU_CLK cycles.
- Self-test:
  - SELF_TEST is sampled only when the packer count is 0 (word boundary) and holds for the whole word.
  - In test mode each strobe uses the counter value (2*SAMPLE_BITS wide) as the sample, then increments the counter. The counter wraps modulo 2^(2*SAMPLE_BITS).
  - The counter does not reset on mode change.
- Packing:
  - Each sample shifts into the pack register from the LSB end, so the first sample ends up in the MSBs.
  - After WORD_BITS/(2*SAMPLE_BITS) samples, the word is pushed to the FIFO on the same cycle the last sample is taken, and the count returns to 0.
- FIFO:
  - Push when full with no pop that cycle: the word is dropped, OVERFLOW is set, and it stays set until RESET.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - Pop on empty never occurs.
  - FIFO_LEVEL is registered and reflects the push/pop of the previous edge.
- SPI FSM, states IDLE, SHIFT, HOLD, GAP:
  - IDLE: when FIFO_LEVEL>0, pop, load the shift register, drive MCU_SS=0 and MOSI=word MSB, and go to SHIFT.
  - SHIFT:
    - SCK low for SCK_DIV cycles, then high for SCK_DIV cycles.
    - On each high-to-low transition MOSI advances to the next bit.
    - After WORD_BITS rising edges, SCK stays low and the FSM goes to HOLD.
  - HOLD: SS stays low for SCK_DIV cycles, then goes to GAP with SS=1.
  - GAP: SS stays high for SS_GAP cycles, then goes to IDLE.
  - MOSI is 0 outside frames.
- Sustained throughput requires WORD_BITS*2*SCK_DIV + SCK_DIV + SS_GAP + 1 MCU_CLK cycles to be no more than the time to collect one word. Any shortfall is absorbed by the FIFO and then reported as OVERFLOW.

Test Plan:
1. Reset: assert RESET for 3 cycles with MAX2769_CLK toggling -> SCK=0, SS=1, MOSI=0, OVERFLOW=0, FIFO_LEVEL=0. No frame starts while RESET is high.
2. Self-test with defaults, SELF_TEST=1, MAX2769_CLK period 240 ns, MCU_CLK period 26 ns:
   - first frames are 0x0123, 0x4567, 0x89AB, 0xCDEF, then the pattern wraps to 0x0123.
   - each frame has exactly 16 SCK rising edges with SCK period 4 cycles.
   - SS is high for at least 4 cycles between frames.
3. Live data: SELF_TEST=0, GPS_I=2'b10, GPS_Q=2'b01 held -> every frame is 0x9999. Change to I=2'b11, Q=2'b00 mid-word -> the transition word shows a mix of 9 and C nibbles in sample order, then frames are 0xCCCC.
4. Overflow: SCK_DIV=64, FIFO_DEPTH=4, fast strobes:
   - FIFO_LEVEL reaches 4, then OVERFLOW=1 on the next completed word.
   - The MCU receives the buffered words in order without corruption.
   - OVERFLOW stays 1 until RESET.
5. Mode switch: toggle SELF_TEST after the 2nd sample of a word -> that word stays entirely live, and the next word is entirely counter pattern.
6. Reset mid-frame: assert RESET after the 5th SCK rise -> SS=1 and SCK=0 on that edge. After release, the first frame starts only once a fresh word is packed, containing counter 0x0123 in self-test.

Source files
------------

// File: rtl/gps_spi_packer_if.sv
// Bus bundle between the GPS packer and its environment: front-end sample
// inputs on one side, SPI link plus status outputs on the other.
interface gps_spi_packer_if #(
  parameter int SAMPLE_BITS = 2,
  parameter int FIFO_DEPTH  = 8
);
  logic                             MAX2769_CLK;
  logic [SAMPLE_BITS-1:0]           GPS_I;
  logic [SAMPLE_BITS-1:0]           GPS_Q;
  logic                             SELF_TEST;
  logic                             MCU_SCK;
  logic                             MCU_SS;
  logic                             MCU_MOSI;
  logic                             OVERFLOW;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_LEVEL;

  // The packer is the SPI master: it consumes samples and drives the link.
  modport master (
    input  MAX2769_CLK, GPS_I, GPS_Q, SELF_TEST,
    output MCU_SCK, MCU_SS, MCU_MOSI, OVERFLOW, FIFO_LEVEL
  );

  // The environment side: supplies samples and observes the link.
  modport slave (
    output MAX2769_CLK, GPS_I, GPS_Q, SELF_TEST,
    input  MCU_SCK, MCU_SS, MCU_MOSI, OVERFLOW, FIFO_LEVEL
  );
endinterface

// File: rtl/gps_spi_packer.sv
// GPS I/Q sample packer: captures MAX2769 samples on MCU_CLK, packs them into
// WORD_BITS words, buffers them in a FIFO and streams them out as SPI master.
//
// state | meaning
// IDLE  | SS high, waiting for a buffered word
// SHIFT | SS low, clocking out the word MSB first (mode 0)
// HOLD  | SS low after the last SCK fall, SCK idle
// GAP   | SS high for the minimum inter-frame gap
module gps_spi_packer #(
  parameter int SAMPLE_BITS = 2,
  parameter int WORD_BITS   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SCK_DIV     = 2,
  parameter int SS_GAP      = 4
) (
  input  logic              MCU_CLK,
  input  logic              RESET,
  gps_spi_packer_if.master  bus
);
  localparam int SW   = 2 * SAMPLE_BITS;
  localparam int SPW  = WORD_BITS / SW;
  localparam int CW   = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int BW   = $clog2(WORD_BITS);
  localparam int TMAX = (SCK_DIV > SS_GAP) ? SCK_DIV : SS_GAP;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  logic [2:0]           mclk_sync;
  logic [SW-1:0]        data_s1, data_s2;
  logic                 strobe;
  logic [CW-1:0]        pack_cnt;
  logic [WORD_BITS-1:0] pack_reg, pack_next;
  logic                 test_mode, use_test;
  logic [SW-1:0]        test_ctr, sample;
  logic                 push, pop, full, wr_en;
  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 overflow;
  state_t               state;
  logic [WORD_BITS-1:0] shreg;
  logic [BW-1:0]        bits_left;
  logic [TW-1:0]        tmr;
  logic                 sck, ss, mosi;

  // Bits [1:0] synchronise MAX2769_CLK; bit 2 is the previous synced value for edge detect.
  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      mclk_sync <= '0;
      data_s1   <= '0;
      data_s2   <= '0;
    end else begin
      mclk_sync <= {mclk_sync[1:0], bus.MAX2769_CLK};
      data_s1   <= {bus.GPS_I, bus.GPS_Q};
      data_s2   <= data_s1;
    end
  end

  assign strobe    = mclk_sync[1] & ~mclk_sync[2];
  // SELF_TEST only takes effect at a word boundary so a word is never mixed.
  assign use_test  = (pack_cnt == '0) ? bus.SELF_TEST : test_mode;
  assign sample    = use_test ? test_ctr : data_s2;
  assign pack_next = WORD_BITS'({pack_reg, sample});
  assign push      = strobe && (pack_cnt == CW'(SPW - 1));

  // Packer: shift samples in from the LSB end, hand off a full word to the FIFO.
  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      pack_cnt  <= '0;
      pack_reg  <= '0;
      test_mode <= 1'b0;
      test_ctr  <= '0;
    end else if (strobe) begin
      if (pack_cnt == '0) test_mode <= bus.SELF_TEST;
      if (use_test) test_ctr <= test_ctr + SW'(1);
      pack_reg <= pack_next;
      pack_cnt <= push ? '0 : pack_cnt + CW'(1);
    end
  end

  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = (state == IDLE) && (level != '0);
  assign wr_en = push && (!full || pop);

  // FIFO storage; a push into a full FIFO that is also popping reuses the freed slot.
  always_ff @(posedge MCU_CLK) begin
    if (wr_en) mem[wr_ptr] <= pack_next;
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(wr_en) - LW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // SPI master FSM with registered SCK/SS/MOSI; tmr is a down-counter per phase.
  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      tmr       <= '0;
      sck       <= 1'b0;
      ss        <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            shreg     <= mem[rd_ptr];
            mosi      <= mem[rd_ptr][WORD_BITS-1];
            ss        <= 1'b0;
            sck       <= 1'b0;
            tmr       <= TW'(SCK_DIV - 1);
            bits_left <= BW'(WORD_BITS - 1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else if (!sck) begin
            sck <= 1'b1;
            tmr <= TW'(SCK_DIV - 1);
          end else begin
            sck <= 1'b0;
            tmr <= TW'(SCK_DIV - 1);
            if (bits_left == '0) begin
              state <= HOLD;
            end else begin
              bits_left <= bits_left - BW'(1);
              shreg     <= {shreg[WORD_BITS-2:0], 1'b0};
              mosi      <= shreg[WORD_BITS-2];
            end
          end
        end
        HOLD: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else begin
            ss    <= 1'b1;
            mosi  <= 1'b0;
            tmr   <= TW'(SS_GAP - 1);
            state <= GAP;
          end
        end
        default: begin
          if (tmr != '0) tmr <= tmr - TW'(1);
          else           state <= IDLE;
        end
      endcase
    end
  end

  assign bus.MCU_SCK    = sck;
  assign bus.MCU_SS     = ss;
  assign bus.MCU_MOSI   = mosi;
  assign bus.OVERFLOW   = overflow;
  assign bus.FIFO_LEVEL = level;
endmodule

// File: tb/tb_gps_spi_packer.sv
// Bench for gps_spi_packer: instance A uses defaults, instance B uses a slow
// SCK and a 4-deep FIFO to provoke overflow. An SPI monitor decodes frames;
// expected words come from a sample-level model of the packing rules.
module tb_gps_spi_packer;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #13 clk = ~clk;

  gps_spi_packer_if #(.SAMPLE_BITS(2), .FIFO_DEPTH(8)) bus_a ();
  gps_spi_packer_if #(.SAMPLE_BITS(2), .FIFO_DEPTH(4)) bus_b ();

  gps_spi_packer dut_a (.MCU_CLK(clk), .RESET(RESET), .bus(bus_a));
  gps_spi_packer #(.FIFO_DEPTH(4), .SCK_DIV(64)) dut_b (.MCU_CLK(clk), .RESET(RESET), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI monitor: frames, SCK period, SS gap and idle levels
  logic [1:0]  sck_v, ss_v, mosi_v;
  assign sck_v  = {bus_b.MCU_SCK,  bus_a.MCU_SCK};
  assign ss_v   = {bus_b.MCU_SS,   bus_a.MCU_SS};
  assign mosi_v = {bus_b.MCU_MOSI, bus_a.MCU_MOSI};
  logic [15:0] rx_a[$], rx_b[$];
  logic [15:0] sh [2];
  int rises[2], since[2], gapc[2], aborts[2], proto_err[2];
  logic [1:0] p_sck = 2'b00, p_ss = 2'b11;
  int max_lvl_b = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      since[d]++;
      if (p_ss[d] && !ss_v[d]) begin
        rises[d] = 0;
        sh[d] = '0;
        if (gapc[d] < 4) proto_err[d]++;
      end
      if (!ss_v[d] && !p_sck[d] && sck_v[d]) begin
        if (rises[d] > 0 && since[d] != ((d == 0) ? 4 : 128)) proto_err[d]++;
        sh[d] = {sh[d][14:0], mosi_v[d]};
        rises[d]++;
        since[d] = 0;
      end
      if (!p_ss[d] && ss_v[d]) begin
        if (rises[d] == 16) begin
          if (d == 0) rx_a.push_back(sh[d]);
          else        rx_b.push_back(sh[d]);
        end else begin
          aborts[d]++;
        end
        gapc[d] = 0;
      end
      if (ss_v[d] === 1'b1) begin
        gapc[d]++;
        if (sck_v[d] !== 1'b0 || mosi_v[d] !== 1'b0) proto_err[d]++;
      end
      p_sck[d] = sck_v[d];
      p_ss[d]  = ss_v[d];
    end
    if (int'(bus_b.FIFO_LEVEL) > max_lvl_b) max_lvl_b = int'(bus_b.FIFO_LEVEL);
  end

  // Reference model for instance A: word-boundary mode latch, wrapping counter
  int mcnt = 0, mctr = 0, mword = 0;
  bit mmode = 1'b0;
  logic [15:0] exp_a[$], exp_b[$];

  task automatic model_reset();
    mcnt = 0; mctr = 0; mword = 0; mmode = 1'b0;
  endtask

  task automatic model_a(input bit st, input int live);
    int val;
    if (mcnt == 0) mmode = st;
    val = mmode ? mctr : live;
    if (mmode) mctr = (mctr + 1) % 16;
    mword = mword * 16 + val;
    mcnt++;
    if (mcnt == 4) begin
      exp_a.push_back(16'(mword));
      mword = 0;
      mcnt = 0;
    end
  endtask

  task automatic send(input int d, input bit st, input logic [1:0] i, input logic [1:0] q, input int hp);
    @(negedge clk);
    if (d == 0) begin
      bus_a.SELF_TEST = st; bus_a.GPS_I = i; bus_a.GPS_Q = q; bus_a.MAX2769_CLK = 1'b1;
    end else begin
      bus_b.SELF_TEST = st; bus_b.GPS_I = i; bus_b.GPS_Q = q; bus_b.MAX2769_CLK = 1'b1;
    end
    repeat (hp) @(negedge clk);
    if (d == 0) bus_a.MAX2769_CLK = 1'b0;
    else        bus_b.MAX2769_CLK = 1'b0;
    repeat (hp) @(negedge clk);
    if (d == 0) model_a(st, int'({i, q}));
  endtask

  task automatic send_a(input bit st, input logic [1:0] i, input logic [1:0] q);
    send(0, st, i, q, int'($urandom_range(7, 5)));
  endtask

  task automatic wait_rx(input int d, input int n, input int budget, input string tag);
    int c = 0;
    while (((d == 0) ? rx_a.size() : rx_b.size()) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, (d == 0) ? rx_a.size() : rx_b.size(), n);
  endtask

  task automatic cmp_a(input string tag);
    while (exp_a.size() > 0 && rx_a.size() > 0) chk(tag, rx_a.pop_front(), exp_a.pop_front());
    exp_a.delete();
    rx_a.delete();
  endtask

  initial begin
    logic [15:0] w;
    int c;
    for (int d = 0; d < 2; d++) begin
      rises[d] = 0; since[d] = 0; gapc[d] = 1000; aborts[d] = 0; proto_err[d] = 0;
    end
    bus_a.MAX2769_CLK = 1'b0; bus_a.GPS_I = '0; bus_a.GPS_Q = '0; bus_a.SELF_TEST = 1'b0;
    bus_b.MAX2769_CLK = 1'b0; bus_b.GPS_I = '0; bus_b.GPS_Q = '0; bus_b.SELF_TEST = 1'b0;

    // 1: reset with MAX2769_CLK toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_a.MAX2769_CLK = ~bus_a.MAX2769_CLK;
      bus_b.MAX2769_CLK = ~bus_b.MAX2769_CLK;
      chk("reset_a", {bus_a.MCU_SCK, bus_a.MCU_SS, bus_a.MCU_MOSI, bus_a.OVERFLOW, bus_a.FIFO_LEVEL}, 32'h40);
      chk("reset_b", {bus_b.MCU_SCK, bus_b.MCU_SS, bus_b.MCU_MOSI, bus_b.OVERFLOW, bus_b.FIFO_LEVEL}, 32'h20);
    end
    bus_a.MAX2769_CLK = 1'b0;
    bus_b.MAX2769_CLK = 1'b0;
    @(negedge clk);
    RESET = 1'b0;
    model_reset();

    // 2: self-test pattern, random live data must be ignored
    for (int k = 0; k < 20; k++) send_a(1'b1, 2'($urandom), 2'($urandom));
    wait_rx(0, 5, 2000, "st_count");
    chk("st_first", rx_a[0], 16'h0123);
    chk("st_wrap",  rx_a[4], 16'h0123);
    cmp_a("st_word");

    // 3: live constant data, mid-word change, then random samples
    for (int k = 0; k < 10; k++) send_a(1'b0, 2'b10, 2'b01);
    for (int k = 0; k < 6; k++)  send_a(1'b0, 2'b11, 2'b00);
    for (int k = 0; k < 8; k++)  send_a(1'b0, 2'($urandom), 2'($urandom));
    wait_rx(0, 6, 2000, "live_count");
    chk("live_9999", rx_a[0], 16'h9999);
    chk("live_mix",  rx_a[2], 16'h99CC);
    chk("live_cccc", rx_a[3], 16'hCCCC);
    cmp_a("live_word");

    // 5: SELF_TEST raised after the 2nd sample of a word
    send_a(1'b0, 2'($urandom), 2'($urandom));
    send_a(1'b0, 2'($urandom), 2'($urandom));
    for (int k = 0; k < 6; k++)  send_a(1'b1, 2'($urandom), 2'($urandom));
    for (int k = 0; k < 4; k++)  send_a(1'b0, 2'($urandom), 2'($urandom));
    wait_rx(0, 3, 2000, "mode_count");
    chk("mode_ctr", rx_a[1], 16'h4567);
    cmp_a("mode_word");
    chk("proto_a", proto_err[0], 0);
    chk("abort_a_none", aborts[0], 0);

    // 6: reset after the 5th SCK rise of a frame
    for (int k = 0; k < 4; k++) send_a(1'b1, 2'($urandom), 2'($urandom));
    c = 0;
    while (!(rises[0] == 5 && bus_a.MCU_SS == 1'b0) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("mid_rise5", rises[0], 5);
    RESET = 1'b1;
    @(negedge clk);
    chk("mid_ss", bus_a.MCU_SS, 1'b1);
    chk("mid_sck", bus_a.MCU_SCK, 1'b0);
    @(negedge clk);
    RESET = 1'b0;
    model_reset();
    exp_a.delete();
    chk("mid_abort", aborts[0], 1);
    chk("mid_rx_none", rx_a.size(), 0);
    repeat (100) @(negedge clk);
    chk("mid_idle_ss", bus_a.MCU_SS, 1'b1);
    chk("mid_level", bus_a.FIFO_LEVEL, 0);
    for (int k = 0; k < 4; k++) send_a(1'b1, 2'($urandom), 2'($urandom));
    wait_rx(0, 1, 2000, "mid_count");
    chk("mid_first", rx_a[0], 16'h0123);
    cmp_a("mid_word");

    // 4: overflow on instance B (first word drains at once, next FIFO_DEPTH are buffered)
    for (int wd = 0; wd < 7; wd++) begin
      w = '0;
      for (int s = 0; s < 4; s++) begin
        logic [3:0] smp;
        smp = 4'($urandom);
        w = {w[11:0], smp};
        send(1, 1'b0, smp[3:2], smp[1:0], 2);
      end
      if (wd < 5) exp_b.push_back(w);
      if (wd == 4) begin
        chk("ovf_level4", bus_b.FIFO_LEVEL, 4);
        chk("ovf_not_yet", bus_b.OVERFLOW, 1'b0);
      end
      if (wd == 5) begin
        chk("ovf_set", bus_b.OVERFLOW, 1'b1);
        chk("ovf_level_full", bus_b.FIFO_LEVEL, 4);
      end
    end
    wait_rx(1, 5, 20000, "ovf_count");
    repeat (300) @(negedge clk);
    chk("ovf_no_extra", rx_b.size(), 5);
    chk("ovf_max_level", max_lvl_b, 4);
    chk("ovf_sticky", bus_b.OVERFLOW, 1'b1);
    chk("ovf_drained", bus_b.FIFO_LEVEL, 0);
    while (exp_b.size() > 0 && rx_b.size() > 0) chk("ovf_word", rx_b.pop_front(), exp_b.pop_front());
    chk("proto_b", proto_err[1], 0);

    RESET = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_cleared", bus_b.OVERFLOW, 1'b0);
    RESET = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
